// File: rtl/rf_pkg.sv
// rf_pkg: register-file geometry and write-request type shared by write-port logic.
package rf_pkg;
    localparam int RF_ADDR_W   = 5;
    localparam int RF_DATA_W   = 32;
    localparam int RF_NUM_REGS = 32;
    localparam int RF_ZERO_IDX = 0;

    typedef struct packed {
        logic [RF_ADDR_W-1:0] rd;
        logic [RF_DATA_W-1:0] data;
    } rf_wreq_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant; the search starts just past the last winner.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int LG_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] i_req_valid,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [LG_W-1:0]    o_grant_idx,
    output logic               o_grant_any
);
    logic [LG_W-1:0] r_last;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_grant_any = 1'b0;
        for (int j = 1; j <= NUM_REQ; j++) begin
            int idx;
            idx = (int'(r_last) + j) % NUM_REQ;
            if (!o_grant_any && i_req_valid[idx]) begin
                o_grant_any  = 1'b1;
                o_grant[idx] = 1'b1;
                o_grant_idx  = LG_W'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_last <= LG_W'(NUM_REQ - 1);
        else if (o_grant_any)
            r_last <= o_grant_idx;
    end
endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the register-file write port between requesters and
// tracks pending destination registers for issue-stage hazard checks.
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = RF_DATA_W,
    parameter int ADDR_W  = RF_ADDR_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_rd,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      claim_valid,
    input  logic [ADDR_W-1:0]         claim_rd,
    input  logic [ADDR_W-1:0]         rs1,
    input  logic [ADDR_W-1:0]         rs2,
    output logic                      rs1_busy,
    output logic                      rs2_busy,
    output logic                      rf_write_enable,
    output logic [ADDR_W-1:0]         rf_rd,
    output logic [DATA_W-1:0]         rf_rd_din
);
    localparam int LG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int NREG = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(RF_ZERO_IDX);

    logic [NUM_REQ-1:0] w_grant;
    logic [LG_W-1:0]    w_idx;
    logic               w_any;
    logic [ADDR_W-1:0]  w_rd;
    logic [DATA_W-1:0]  w_data;

    logic               r_stage_valid;
    logic [ADDR_W-1:0]  r_stage_rd;
    logic [DATA_W-1:0]  r_stage_data;
    logic [NREG-1:0]    r_pending;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .LG_W(LG_W)) u_arb (
        .clk         (clk),
        .reset       (reset),
        .i_req_valid (req_valid),
        .o_grant     (w_grant),
        .o_grant_idx (w_idx),
        .o_grant_any (w_any)
    );

    // Only the granted slice is ever selected, so idle requesters cannot leak X.
    assign w_rd      = req_rd[int'(w_idx)*ADDR_W +: ADDR_W];
    assign w_data    = req_data[int'(w_idx)*DATA_W +: DATA_W];
    assign req_ready = reset ? w_grant : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stage_valid <= 1'b0;
            r_stage_rd    <= '0;
            r_stage_data  <= '0;
            r_pending     <= '0;
        end else begin
            r_stage_valid <= w_any;
            if (w_any) begin
                r_stage_rd   <= w_rd;
                r_stage_data <= w_data;
            end
            if (w_any && w_rd != ZERO)
                r_pending[w_rd] <= 1'b0;
            // Ordered after the clear so a same-edge reclaim keeps the bit set.
            if (claim_valid && claim_rd != ZERO)
                r_pending[claim_rd] <= 1'b1;
        end
    end

    assign rf_write_enable = r_stage_valid && r_stage_rd != ZERO;
    assign rf_rd           = r_stage_rd;
    assign rf_rd_din       = r_stage_data;

    // The staged write is still invisible to asynchronous reads, so it counts as busy.
    assign rs1_busy = rs1 != ZERO && (r_pending[rs1] || (r_stage_valid && r_stage_rd == rs1));
    assign rs2_busy = rs2 != ZERO && (r_pending[rs2] || (r_stage_valid && r_stage_rd == rs2));
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed stimulus with a write scoreboard drained by a port monitor.
module tb_rf_write_arbiter;
    import rf_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [4:0]  rd0, rd1;
    logic [31:0] d0, d1;
    logic [1:0]  req_ready;
    logic        claim_valid;
    logic [4:0]  claim_rd, rs1, rs2;
    logic        rs1_busy, rs2_busy, rf_write_enable;
    logic [4:0]  rf_rd;
    logic [31:0] rf_rd_din;

    int cyc = 0;
    int n_pass = 0;
    int n_total = 0;
    bit no_push = 1'b0;

    typedef struct {
        int       due;
        rf_wreq_t w;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rf_write_arbiter #(.NUM_REQ(2), .DATA_W(32), .ADDR_W(5)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_rd          ({rd1, rd0}),
        .req_data        ({d1, d0}),
        .req_ready       (req_ready),
        .claim_valid     (claim_valid),
        .claim_rd        (claim_rd),
        .rs1             (rs1),
        .rs2             (rs2),
        .rs1_busy        (rs1_busy),
        .rs2_busy        (rs2_busy),
        .rf_write_enable (rf_write_enable),
        .rf_rd           (rf_rd),
        .rf_rd_din       (rf_rd_din)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Every register-file write must match the oldest expected write, on its due cycle.
    always @(negedge clk) begin
        if (rf_write_enable === 1'b1) begin
            if (q.size() == 0) begin
                n_total++;
                $display("FAIL spurious_write: rd=%0d data=%0h while none expected", rf_rd, rf_rd_din);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("wr_rd", 64'(rf_rd), 64'(e.w.rd));
                chk("wr_data", 64'(rf_rd_din), 64'(e.w.data));
                chk("wr_cycle", 64'(cyc), 64'(e.due));
            end
        end
    end

    // Called just after a rising edge: drive, check combinational outputs, log accepted writes.
    task automatic step(input string tag,
                        input logic [1:0] v, input logic [4:0] r0, input logic [31:0] x0,
                        input logic [4:0] r1, input logic [31:0] x1,
                        input logic cv, input logic [4:0] crd,
                        input logic [4:0] q1, input logic [4:0] q2,
                        input logic [1:0] er, input logic eb1, input logic eb2);
        req_valid = v; rd0 = r0; d0 = x0; rd1 = r1; d1 = x1;
        claim_valid = cv; claim_rd = crd; rs1 = q1; rs2 = q2;
        #2;
        chk({tag, "_ready"}, 64'(req_ready), 64'(er));
        chk({tag, "_rs1_busy"}, 64'(rs1_busy), 64'(eb1));
        chk({tag, "_rs2_busy"}, 64'(rs2_busy), 64'(eb2));
        if (!no_push && er[0] && r0 != 5'd0) q.push_back('{cyc + 1, '{r0, x0}});
        if (!no_push && er[1] && r1 != 5'd0) q.push_back('{cyc + 1, '{r1, x1}});
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b0; req_valid = 2'b11; rd0 = 5'd5; rd1 = 5'd6; d0 = '1; d1 = '1;
        claim_valid = 1'b0; claim_rd = '0; rs1 = 5'd5; rs2 = 5'd6;
        #3;
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_we", 64'(rf_write_enable), 64'd0);
        chk("rst_rd", 64'(rf_rd), 64'd0);
        chk("rst_din", 64'(rf_rd_din), 64'd0);
        chk("rst_busy", 64'({rs1_busy, rs2_busy}), 64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;

        // Reset mid-write: the staged write to x5 and the claim of x5 must vanish.
        no_push = 1'b1;
        step("rmw_accept", 2'b01, 5'd5, 32'hDEAD_BEEF, 5'd0, 32'd0, 1'b1, 5'd5, 5'd5, 5'd5, 2'b01, 1'b0, 1'b0);
        no_push = 1'b0;
        req_valid = 2'b00; claim_valid = 1'b0;
        #1;
        chk("rmw_staged_we", 64'(rf_write_enable), 64'd1);
        reset = 1'b0;
        #1;
        chk("rmw_we_dropped", 64'(rf_write_enable), 64'd0);
        chk("rmw_rd_zero", 64'(rf_rd), 64'd0);
        chk("rmw_din_zero", 64'(rf_rd_din), 64'd0);
        chk("rmw_busy_in_reset", 64'({rs1_busy, rs2_busy}), 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("rmw_busy_after", 64'({rs1_busy, rs2_busy}), 64'd0);

        // Fairness: reset restored last_grant, so requester 0 wins first.
        for (int i = 0; i < 6; i++)
            step("rr", 2'b11, 5'd1, 32'hA000_0000 + 32'(i), 5'd2, 32'hB000_0000 + 32'(i),
                 1'b0, 5'd0, 5'd0, 5'd0, (i % 2 == 0) ? 2'b01 : 2'b10, 1'b0, 1'b0);

        // Single write latency.
        step("single", 2'b01, 5'd3, 32'h0000_1234, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b01, 1'b0, 1'b0);
        step("idle_a", 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
        step("idle_b", 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);

        // Scoreboard hazard on x7, retired by requester 1.
        step("hz_claim", 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd7, 5'd0, 2'b00, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            step("hz_wait", 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd7, 5'd0, 2'b00, 1'b1, 1'b0);
        step("hz_grant", 2'b10, 5'd0, 32'd0, 5'd7, 32'h0000_7777, 1'b0, 5'd0, 5'd7, 5'd0, 2'b10, 1'b1, 1'b0);
        step("hz_staged", 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd7, 5'd0, 2'b00, 1'b1, 1'b0);
        step("hz_clear", 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd7, 5'd0, 2'b00, 1'b0, 1'b0);

        // Same-edge reclaim and retire of x9: the claim must survive.
        step("sc_claim", 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd0, 5'd9, 2'b00, 1'b0, 1'b0);
        step("sc_both", 2'b01, 5'd9, 32'h0000_9999, 5'd0, 32'd0, 1'b1, 5'd9, 5'd0, 5'd9, 2'b01, 1'b0, 1'b1);
        step("sc_staged", 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd9, 2'b00, 1'b0, 1'b1);
        step("sc_drained", 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd9, 2'b00, 1'b0, 1'b1);

        // x0: handshake completes, no write, never busy.
        step("x0_write", 2'b01, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0, 5'd9, 2'b01, 1'b0, 1'b1);
        step("x0_staged", 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd9, 2'b00, 1'b0, 1'b1);
        step("x0_after", 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd9, 2'b00, 1'b0, 1'b1);

        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
